// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 16x oversampled 8E1 deframer feeding a byte FIFO
// Flow control via registered rx_rts_n; parity/frame/overrun errors are one-clk pulses.
module uart_rx #(
  parameter int DEPTH      = 8,
  parameter int RTS_THRESH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     rx,
  input  logic                     rx_enable,
  input  logic                     flush,
  output logic                     rx_rts_n,
  output logic [7:0]               rxdata,
  output logic                     rxdata_valid,
  input  logic                     rxdata_ready,
  output logic                     rxfifo_full,
  output logic                     rxfifo_empty,
  output logic [$clog2(DEPTH):0]   rxfifo_level,
  output logic                     err_parity,
  output logic                     err_frame,
  output logic                     err_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  state_e        state_q, state_d;
  logic [3:0]    s_q, s_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bad_q, par_bad_d;
  logic          frame_done;
  logic          fall_edge;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          rts_n_q, rts_n_d;
  logic          err_parity_q, err_parity_d;
  logic          err_frame_q, err_frame_d;
  logic          err_overrun_q, err_overrun_d;

  logic          good_byte;
  logic          pop;
  logic          room;
  logic          push;

  // The previous-value register only advances on ticks, so the falling edge is
  // seen as a tick-to-tick transition and cannot slip between two ticks.
  assign fall_edge = rx_prev_q & ~rx_sync_q;

  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = tick ? rx_sync_q : rx_prev_q;
    state_d    = state_q;
    s_d        = s_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    frame_done = 1'b0;
    if (!rx_enable) begin
      state_d  = ST_IDLE;
      s_d      = 4'd0;
      bitcnt_d = 3'd0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (fall_edge) begin
            s_d     = 4'd0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (s_q == 4'd7) begin
            s_d = 4'd0;
            if (rx_sync_q) begin
              state_d = ST_IDLE;
            end else begin
              bitcnt_d = 3'd0;
              state_d  = ST_DATA;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (s_q == 4'd15) begin
            shift_d[bitcnt_q] = rx_sync_q;
            s_d               = 4'd0;
            bitcnt_d          = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = ST_PARITY;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
        ST_PARITY: begin
          if (s_q == 4'd15) begin
            par_bad_d = rx_sync_q ^ (^shift_q);
            s_d       = 4'd0;
            state_d   = ST_STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
        ST_STOP: begin
          if (s_q == 4'd15) begin
            frame_done = 1'b1;
            s_d        = 4'd0;
            state_d    = ST_IDLE;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          s_d     = 4'd0;
        end
      endcase
    end
  end

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign good_byte = frame_done & rx_sync_q & ~par_bad_q;
  assign pop       = (level_q != '0) & rxdata_ready;
  assign room      = (level_q < LW'(DEPTH)) | pop;
  assign push      = good_byte & ~flush & room;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    err_parity_d  = frame_done & rx_sync_q & par_bad_q;
    err_frame_d   = frame_done & ~rx_sync_q;
    err_overrun_d = good_byte & ~flush & ~room;
    rts_n_d       = ~(rx_enable & (level_q < LW'(RTS_THRESH)));
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      state_q       <= ST_IDLE;
      s_q           <= 4'd0;
      bitcnt_q      <= 3'd0;
      shift_q       <= 8'd0;
      par_bad_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rts_n_q       <= 1'b1;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rx_sync_q     <= rx_sync_d;
      rx_prev_q     <= rx_prev_d;
      state_q       <= state_d;
      s_q           <= s_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rts_n_q       <= rts_n_d;
      err_parity_q  <= err_parity_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rxdata       = mem_q[rd_ptr_q];
  assign rxdata_valid = (level_q != '0);
  assign rxfifo_empty = (level_q == '0);
  assign rxfifo_full  = (level_q == LW'(DEPTH));
  assign rxfifo_level = level_q;
  assign rx_rts_n     = rts_n_q;
  assign err_parity   = err_parity_q;
  assign err_frame    = err_frame_q;
  assign err_overrun  = err_overrun_q;

endmodule
